// File: rtl/sideways_bank_mem.sv
// Sideways ROM/RAM bank memory: ROMSEL latch, &8000-&BFFF read/write window and a
// byte-stream bank loader. Define SIDEWAYS_RAM_EN to enable CPU writes to RAM_MASK banks.
module sideways_bank_mem #(
  parameter int unsigned  NUM_BANKS = 4,
  parameter logic [15:0]  RAM_MASK  = 16'h000C
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        clk_en,
  input  logic        PHI_2,
  input  logic        RnW,
  input  logic [15:0] A,
  input  logic [7:0]  DIN,
  input  logic        nROMSEL,
  output logic [7:0]  DOUT,
  output logic [3:0]  ROMSEL,
  input  logic        ld_start,
  input  logic [3:0]  ld_bank,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        ld_abort,
  output logic        ld_done,
  output logic        ld_busy
);

  localparam int unsigned BANK_AW = 14;
  localparam int unsigned DEPTH   = NUM_BANKS << BANK_AW;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [4:0]  NB      = 5'(NUM_BANKS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      bank_q, bank_d;
  logic [13:0]     cnt_q, cnt_d;
  logic [7:0]      dout_q;
  logic [3:0]      romsel_q;

  logic [7:0]      mem [DEPTH];

  logic            win_c, bank_valid_c, locked_c, rd_slot_c, start_ok_c;
  logic            ld_we_c, cpu_we_c, mem_we_c;
  logic [AW-1:0]   cpu_addr_c, ld_addr_c, mem_waddr_c;
  logic [7:0]      mem_wdata_c;

  assign win_c        = (A[15:14] == 2'b10);
  assign bank_valid_c = ({1'b0, romsel_q} < NB);
  assign locked_c     = ld_busy && (romsel_q == bank_q);
  assign rd_slot_c    = clk_en && !PHI_2 && win_c;
  assign start_ok_c   = ld_start && ({1'b0, ld_bank} < NB);
  assign cpu_addr_c   = AW'({romsel_q, A[13:0]});
  assign ld_addr_c    = AW'({bank_q, cnt_q});

  // A byte offered together with ld_abort is discarded.
  assign ld_we_c      = ld_ready && ld_valid && !ld_abort;

`ifdef SIDEWAYS_RAM_EN
  assign cpu_we_c = clk_en && PHI_2 && !RnW && win_c && bank_valid_c &&
                    RAM_MASK[romsel_q] && !locked_c;
`else
  logic unused_wr_c;
  assign unused_wr_c = ^{RnW, RAM_MASK};
  assign cpu_we_c    = 1'b0;
`endif

  // Loader and CPU never write together: ld_ready is low in every CPU slot.
  assign mem_we_c    = cpu_we_c || ld_we_c;
  assign mem_waddr_c = ld_we_c ? ld_addr_c : cpu_addr_c;
  assign mem_wdata_c = ld_we_c ? ld_data : DIN;

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // CPU-side registers; a same-slot ROMSEL write is seen by the next read only.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      dout_q   <= 8'h00;
      romsel_q <= 4'h0;
    end else begin
      if (rd_slot_c) dout_q <= (bank_valid_c && !locked_c) ? mem[cpu_addr_c] : 8'hFF;
      if (clk_en && !nROMSEL) romsel_q <= DIN[3:0];
    end
  end

  assign DOUT   = dout_q;
  assign ROMSEL = romsel_q;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      bank_q  <= 4'h0;
      cnt_q   <= 14'h0000;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          state_d = ST_LOAD;
          bank_d  = ld_bank;
          cnt_d   = 14'h0000;
        end
      end
      ST_LOAD: begin
        if (ld_abort) begin
          state_d = ST_IDLE;
        end else if (ld_we_c) begin
          cnt_d = cnt_q + 14'd1;
          if (cnt_q == 14'h3FFF) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_busy  = 1'b1;
        ld_ready = !clk_en;
      end
      ST_DONE: ld_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sideways_bank_mem.sv
// Directed bench for sideways_bank_mem: ROMSEL/window reads, bank loads with abort and
// reset, sideways RAM writes (expectation follows SIDEWAYS_RAM_EN).
module tb_sideways_bank_mem;

  logic        clk = 1'b0;
  logic        nRESET;
  logic        clk_en;
  logic        PHI_2;
  logic        RnW;
  logic [15:0] A;
  logic [7:0]  DIN;
  logic        nROMSEL;
  logic [7:0]  DOUT;
  logic [3:0]  ROMSEL;
  logic        ld_start;
  logic [3:0]  ld_bank;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_abort;
  logic        ld_done;
  logic        ld_busy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  sideways_bank_mem dut (
    .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .PHI_2(PHI_2), .RnW(RnW),
    .A(A), .DIN(DIN), .nROMSEL(nROMSEL), .DOUT(DOUT), .ROMSEL(ROMSEL),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_abort(ld_abort), .ld_done(ld_done), .ld_busy(ld_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input bit sel, input logic [3:0] rs, input bit phi, input bit rnw,
                      input logic [15:0] addr, input logic [7:0] d);
    clk_en  = 1'b1;
    nROMSEL = !sel;
    DIN     = sel ? {4'h0, rs} : d;
    PHI_2   = phi;
    RnW     = rnw;
    A       = addr;
    cyc();
    clk_en  = 1'b0;
    nROMSEL = 1'b1;
    PHI_2   = 1'b0;
    RnW     = 1'b1;
  endtask

  task automatic rd(input logic [15:0] addr);
    slot(1'b0, 4'h0, 1'b0, 1'b1, addr, 8'h00);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] d);
    slot(1'b0, 4'h0, 1'b1, 1'b0, addr, d);
  endtask

  task automatic set_rs(input logic [3:0] v);
    slot(1'b1, v, 1'b1, 1'b1, 16'h0000, 8'h00);
  endtask

  // Streams n bytes (salt ^ index) into a bank with clk_en toggling every cycle.
  // do_abort presents byte n-1 together with ld_abort; do_ops runs CPU reads mid-load.
  task automatic load(input logic [3:0] bank, input logic [7:0] salt, input int n,
                      input bit do_abort, input bit do_ops);
    int idx   = 0;
    int viol  = 0;
    int dones = 0;
    int ph    = 0;
    bit rdy, op;
    ld_bank  = bank;
    ld_start = 1'b1;
    clk_en   = 1'b0;
    cyc();
    ld_start = 1'b0;
    chk("busy_after_start", 32'(ld_busy), 32'd1);
    for (int c = 0; c < 40000 && idx < n; c++) begin
      clk_en   = c[0];
      ld_valid = 1'b1;
      ld_data  = salt ^ 8'(idx);
      ld_abort = do_abort && (idx == n - 1) && !clk_en;
      op       = do_ops && clk_en && (idx >= 1000) && (ph < 4);
      if (op) begin
        case (ph)
          0: begin nROMSEL = 1'b0; DIN = 8'h03; PHI_2 = 1'b1; end
          1: begin PHI_2 = 1'b0; RnW = 1'b1; A = 16'h8010; end
          2: begin nROMSEL = 1'b0; DIN = 8'h01; PHI_2 = 1'b1; end
          default: begin PHI_2 = 1'b0; RnW = 1'b1; A = 16'h8010; end
        endcase
      end
      #1;
      rdy = ld_ready;
      if (clk_en && rdy) viol++;
      @(posedge clk);
      #1;
      if (ld_abort) idx = n;
      else if (rdy) idx++;
      if (ld_done) dones++;
      ld_abort = 1'b0;
      nROMSEL  = 1'b1;
      PHI_2    = 1'b0;
      A        = 16'h0000;
      if (op) begin
        if (ph == 1) chk("locked_bank_read", 32'(DOUT), 32'h0000_00FF);
        if (ph == 3) chk("other_bank_read_in_load", 32'(DOUT), 32'h0000_004A);
        ph++;
      end
    end
    ld_valid = 1'b0;
    clk_en   = 1'b0;
    chk("load_finished_in_budget", 32'(idx), 32'(n));
    chk("ready_in_cpu_slot", 32'(viol), 32'd0);
    chk("done_pulse_count", 32'(dones), (n == 16384 && !do_abort) ? 32'd1 : 32'd0);
    if (do_ops) chk("cpu_ops_ran", 32'(ph), 32'd4);
  endtask

  initial begin
    nRESET = 1'b0; clk_en = 1'b0; PHI_2 = 1'b0; RnW = 1'b1; A = 16'h0000;
    DIN = 8'h00; nROMSEL = 1'b1; ld_start = 1'b0; ld_bank = 4'h0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_abort = 1'b0;
    #12;
    chk("rst_dout", 32'(DOUT), 32'h00);
    chk("rst_romsel", 32'(ROMSEL), 32'h0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    nRESET = 1'b1;
    cyc();

    // Start into an unpopulated bank is ignored.
    ld_bank = 4'h5; ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
    chk("bad_bank_start_ignored", 32'(ld_busy), 32'd0);

    load(4'h1, 8'h5A, 16384, 1'b0, 1'b0);
    chk("done_after_last_byte", 32'(ld_done), 32'd1);
    cyc();
    chk("done_one_cycle", 32'(ld_done), 32'd0);
    chk("busy_clear_after_done", 32'(ld_busy), 32'd0);

    set_rs(4'h1);
    chk("romsel_write", 32'(ROMSEL), 32'h1);
    rd(16'h8000);
    chk("bank1_8000", 32'(DOUT), 32'h5A);
    rd(16'hBFFF);
    chk("bank1_bfff", 32'(DOUT), 32'hA5);
    rd(16'hC000);
    chk("outside_window_holds", 32'(DOUT), 32'hA5);
    rd(16'h8123);
    chk("bank1_8123", 32'(DOUT), 32'h79);

    // ROMSEL write and read in one slot: read uses the old bank.
    slot(1'b1, 4'h3, 1'b0, 1'b1, 16'h8005, 8'h00);
    chk("same_slot_old_romsel", 32'(DOUT), 32'h5F);
    chk("same_slot_romsel_new", 32'(ROMSEL), 32'h3);

    set_rs(4'hF);
    rd(16'h8000);
    chk("invalid_bank_f", 32'(DOUT), 32'hFF);
    set_rs(4'h1);
    rd(16'h8001);
    chk("bank1_8001", 32'(DOUT), 32'h5B);
    set_rs(4'h4);
    rd(16'h8000);
    chk("invalid_bank_4", 32'(DOUT), 32'hFF);

    load(4'h3, 8'h00, 16384, 1'b0, 1'b1);
    chk("bank3_done", 32'(ld_done), 32'd1);
    cyc();

    set_rs(4'h3);
    rd(16'hBFFF);
    chk("bank3_bfff", 32'(DOUT), 32'hFF);
    rd(16'h9234);
    chk("bank3_9234", 32'(DOUT), 32'h34);
    wr(16'h9234, 8'hA5);
    rd(16'h9234);
`ifdef SIDEWAYS_RAM_EN
    chk("ram_write_bank3", 32'(DOUT), 32'hA5);
`else
    chk("ram_write_dropped", 32'(DOUT), 32'h34);
`endif
    set_rs(4'h1);
    wr(16'h9234, 8'h77);
    rd(16'h9234);
    chk("rom_write_dropped", 32'(DOUT), 32'h6E);

    // Abort after 100 bytes; byte 100 keeps its earlier value.
    load(4'h1, 8'hC3, 101, 1'b1, 1'b0);
    chk("abort_busy_drop", 32'(ld_busy), 32'd0);
    chk("abort_no_done", 32'(ld_done), 32'd0);
    rd(16'h8000);
    chk("abort_byte0", 32'(DOUT), 32'hC3);
    rd(16'h8063);
    chk("abort_byte99", 32'(DOUT), 32'hA0);
    rd(16'h8064);
    chk("abort_byte100_kept", 32'(DOUT), 32'h3E);

    set_rs(4'h3);
    rd(16'h8001);
    chk("pre_reset_dout", 32'(DOUT), 32'h01);
    load(4'h2, 8'h11, 50, 1'b0, 1'b0);
    chk("mid_load_busy", 32'(ld_busy), 32'd1);
    chk("mid_load_ready", 32'(ld_ready), 32'd1);
    #2;
    nRESET = 1'b0;
    #1;
    chk("async_rst_dout", 32'(DOUT), 32'h00);
    chk("async_rst_romsel", 32'(ROMSEL), 32'h0);
    chk("async_rst_ready", 32'(ld_ready), 32'd0);
    chk("async_rst_done", 32'(ld_done), 32'd0);
    chk("async_rst_busy", 32'(ld_busy), 32'd0);
    #3;
    nRESET = 1'b1;
    cyc();
    set_rs(4'h2);
    rd(16'h8000);
    chk("kept_bank2_byte0", 32'(DOUT), 32'h11);
    rd(16'h8031);
    chk("kept_bank2_byte49", 32'(DOUT), 32'h20);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sideways_bank_mem.md
# sideways_bank_mem

Parametrised sideways ROM/RAM bank memory for the BBC micro core: it holds up to 16 banks of 16 KiB and maps the bank selected by the ROMSEL latch into CPU space &8000–&BFFF. Any bank can be flagged as sideways RAM. A byte-stream loader port refills one whole bank from the SDHC side without halting the CPU. This block replaces the fixed two-ROM case statement and the ROM_BANK latch in the top level.

## Interface
Parameters:
- NUM_BANKS, 4: number of populated banks, 1..16; bank n occupies internal bytes n*16384 .. n*16384+16383.
- RAM_MASK, 16'h000C: bit n set means bank n is CPU-writable sideways RAM.

Ports:
- clk  in  1  system pixel clock; single clock domain.
- nRESET  in  1  asynchronous active-low reset.
- clk_en  in  1  processor slot enable (PROC_en); all CPU-side actions are qualified by it.
- PHI_2  in  1  CPU phase 2.
- RnW  in  1  CPU read/not-write.
- A  in  16  CPU address bus.
- DIN  in  8  CPU write data.
- nROMSEL  in  1  active-low ROMSEL register select, already decoded for writes only.
- DOUT  out  8  registered read data for the sideways window.
- ROMSEL  out  4  current ROMSEL latch value.
- ld_start  in  1  one-cycle pulse that starts a load into ld_bank.
- ld_bank  in  4  target bank, sampled on ld_start.
- ld_valid  in  1  loader byte available.
- ld_data  in  8  loader byte.
- ld_ready  out  1  block accepts a byte this cycle.
- ld_abort  in  1  aborts the load in progress.
- ld_done  out  1  one-cycle pulse after the final byte is written.
- ld_busy  out  1  high while in the LOAD state.

## Operation
- Sideways window: A[15:14]==2'b10.
- ROMSEL: on clk_en & ~nROMSEL, ROMSEL <= DIN[3:0].
- A bank is valid when ROMSEL < NUM_BANKS.
- A bank is locked when ld_busy is high and ROMSEL == ld_bank.
- Read: on clk_en & ~PHI_2 & window, DOUT <= mem[{ROMSEL,A[13:0]}].
  - If the bank is invalid or locked, DOUT <= 8'hFF instead.
  - Outside the window, DOUT holds its value.
- CPU write: on clk_en & PHI_2 & ~RnW & window & valid & RAM_MASK[ROMSEL] & ~locked, mem[{ROMSEL,A[13:0]}] <= DIN.
  - Writes that fail any of these conditions are dropped silently.
- Loader FSM states:
  - IDLE: on ld_start, latch ld_bank, clear the 14-bit counter cnt, and go to LOAD. If ld_bank >= NUM_BANKS, ignore the start and stay in IDLE.
  - LOAD: ld_ready = ~clk_en. On ld_valid & ld_ready, mem[{bank,cnt}] <= ld_data and cnt increments. If the accepted byte has cnt==14'h3FFF, go to DONE.
  - DONE: assert ld_done for one cycle, then go to IDLE.
- ld_abort in LOAD or DONE: go to IDLE next cycle with no ld_done. A byte presented in the same cycle as ld_abort is not written.
- ld_start outside IDLE is ignored.
- The loader ignores RAM_MASK; any populated bank can be loaded.

## Timing
- Reset values: DOUT=8'h00, ROMSEL=4'h0, ld_ready=0, ld_done=0, ld_busy=0, state=IDLE, cnt=0.
- Reset does not clear memory contents. Reset during a load leaves a partially written bank.
- Read latency: DOUT is valid on the clk edge after the qualifying slot and stays stable until the next qualifying slot.
- ROMSEL write and read in the same slot: the read uses the old ROMSEL.
- A CPU write and a loader write never occur in the same cycle, because ld_ready is low whenever clk_en is high.
- Load duration: at least 16384 accepted bytes. ld_done rises exactly one cycle after the cycle that accepts byte 16383.
- cnt wraps only through the transition to DONE; there is no second pass.

## Configuration
- SIDEWAYS_RAM_EN defined: CPU writes to banks flagged in RAM_MASK behave as described above.
- SIDEWAYS_RAM_EN undefined:
  - All CPU writes into the window are dropped and RAM_MASK is ignored.
  - The write-port logic is not synthesised; the loader is the only write path.

## Test plan
- Reset, then write ROMSEL=1 and read &8000 -> DOUT equals the bank-1 preload byte one clk after the slot. Write ROMSEL=4'hF with NUM_BANKS=4 -> reads return 8'hFF.
- SIDEWAYS_RAM_EN defined, ROMSEL=2, CPU writes 8'hA5 to &9234 -> readback is 8'hA5. Same write with ROMSEL=0 -> readback unchanged.
- ld_start with ld_bank=3, stream 16384 bytes (byte i = i[7:0]), with ld_valid held and clk_en toggling:
  - ld_ready is never high while clk_en is high;
  - ld_done pulses once after the last byte;
  - CPU read of bank 3 at &BFFF -> 8'hFF.
- During that load, with ROMSEL=3, CPU reads -> 8'hFF. With ROMSEL=0, reads return normal data.
- ld_abort after 100 bytes, coinciding with ld_valid -> byte 100 is not written, ld_done stays low, ld_busy drops the next cycle, and a new ld_start is accepted.
- Assert nRESET mid-load -> all outputs return to their reset values asynchronously and bytes already loaded are retained.
